// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//
// Fetch-side program counter and control-flow redirect controller for the
// RV32I core. EX supplies a resolved branch/jump decision. This block then
// does four things:
//   - computes the redirect target,
//   - steers the fetch PC to that target,
//   - squashes wrong-path IF/ID instructions for a fixed number of unstalled
//     cycles,
//   - parks a redirect that arrives while fetch is stalled.
// A target with bit 1 set is not taken. Instead it is reported as an
// instruction-address-misaligned event.
//
// Parameters
//   RESET_PC      fetch PC after reset
//   FLUSH_CYCLES  unstalled cycles flush_out stays high after a redirect (1..7)
//
// Ports
//   clk_in            core clock, rising-edge
//   rst_n_in          asynchronous active-low reset
//   stall_in          fetch stall; PC and flush countdown hold while high
//   ex_valid_in       EX stage holds a valid instruction
//   branch_taken_in   taken flag from the EX comparator (1 for JAL/JALR)
//   opcode_6_to_2_in  EX opcode bits [6:2]
//   ex_pc_in          PC of the EX instruction
//   imm_in            sign-extended immediate of the EX instruction
//   rs1_in            forwarded rs1 value (JALR base)
//   pc_out            registered fetch PC
//   link_addr_out     combinational ex_pc_in + 4 (rd value for JAL/JALR)
//   redirect_out      one-cycle pulse: PC was loaded with a target last edge
//   flush_out         registered IF/ID squash
//   misaligned_out    one-cycle pulse: misaligned control-flow target seen
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        stall_in,
    input  logic        ex_valid_in,
    input  logic        branch_taken_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr_out,
    output logic        redirect_out,
    output logic        flush_out,
    output logic        misaligned_out
);

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [2:0]  flush_cnt;
    logic [2:0]  flush_cnt_next;
    logic        pending_valid;
    logic [31:0] pending_target;

    logic        is_ctrl_flow;
    logic        is_jalr;
    logic        req;
    logic        req_misaligned;
    logic [31:0] target;

    assign link_addr_out = ex_pc_in + 32'd4;

    // Decode the EX decision and form the redirect target. JALR clears bit 0
    // of its sum. Branch and JAL are PC-relative.
    always_comb begin
        is_ctrl_flow = 1'b0;
        is_jalr      = 1'b0;
        case (opcode_6_to_2_in)
            OPC_BRANCH: is_ctrl_flow = 1'b1;
            OPC_JAL:    is_ctrl_flow = 1'b1;
            OPC_JALR: begin
                is_ctrl_flow = 1'b1;
                is_jalr      = 1'b1;
            end
            default:    is_ctrl_flow = 1'b0;
        endcase

        if (is_jalr)
            target = (rs1_in + imm_in) & ~32'h1;
        else
            target = ex_pc_in + imm_in;
    end

    // While a flush is counting down or a redirect is parked, anything in EX
    // is on the wrong path. Requests from it are therefore dropped.
    assign req = ex_valid_in & branch_taken_in & is_ctrl_flow &
                 (flush_cnt == 3'd0) & ~pending_valid;
    assign req_misaligned = req & target[1];

    // The flush countdown reloads on any accepted request, aligned or not.
    // Otherwise it drains by one per unstalled cycle.
    always_comb begin
        if (req)
            flush_cnt_next = FLUSH_LOAD;
        else if (!stall_in && flush_cnt != 3'd0)
            flush_cnt_next = flush_cnt - 3'd1;
        else
            flush_cnt_next = flush_cnt;
    end

    // Fetch PC, parked redirect and registered status pulses. Priority order:
    //   1. A misaligned request only raises the flag. The PC keeps its normal
    //      sequence.
    //   2. An aligned request either redirects now or parks if fetch is
    //      stalled.
    //   3. A parked target is released on the first unstalled edge.
    //   4. Otherwise the PC steps by 4 when not stalled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc_out         <= RESET_PC;
            redirect_out   <= 1'b0;
            flush_out      <= 1'b0;
            misaligned_out <= 1'b0;
            flush_cnt      <= 3'd0;
            pending_valid  <= 1'b0;
            pending_target <= 32'h0;
        end else begin
            redirect_out   <= 1'b0;
            misaligned_out <= 1'b0;
            flush_cnt      <= flush_cnt_next;
            flush_out      <= (flush_cnt_next != 3'd0);

            if (req_misaligned) begin
                misaligned_out <= 1'b1;
                if (!stall_in)
                    pc_out <= pc_out + 32'd4;
            end else if (req) begin
                if (stall_in) begin
                    pending_valid  <= 1'b1;
                    pending_target <= target;
                end else begin
                    pc_out       <= target;
                    redirect_out <= 1'b1;
                end
            end else if (pending_valid && !stall_in) begin
                pc_out        <= pending_target;
                pending_valid <= 1'b0;
                redirect_out  <= 1'b1;
            end else if (!stall_in) begin
                pc_out <= pc_out + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit
//
// Self-checking bench for pc_redirect_unit. It runs two phases:
//   - directed scenarios from the block's bring-up plan,
//   - a randomized run.
// Both phases are compared every cycle against a behavioural model. The model
// tracks the PC, the remaining squash cycles and an optional parked target.
// ---------------------------------------------------------------------------
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic        taken;
    logic [4:0]  opcode;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        redirect;
    logic        flush;
    logic        misaligned;

    int checks_done;
    int checks_failed;

    // Reference model state: fetch PC, squash cycles still owed, parked target,
    // and the three status flags the DUT should be showing now.
    logic [31:0] m_pc;
    int          m_squash_left;
    bit          m_parked;
    logic [31:0] m_parked_target;
    bit          m_redirect;
    bit          m_flush;
    bit          m_misaligned;

    pc_redirect_unit #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .stall_in         (stall),
        .ex_valid_in      (ex_valid),
        .branch_taken_in  (taken),
        .opcode_6_to_2_in (opcode),
        .ex_pc_in         (ex_pc),
        .imm_in           (imm),
        .rs1_in           (rs1),
        .pc_out           (pc),
        .link_addr_out    (link_addr),
        .redirect_out     (redirect),
        .flush_out        (flush),
        .misaligned_out   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_pc            = RESET_PC;
        m_squash_left   = 0;
        m_parked        = 0;
        m_parked_target = 32'h0;
        m_redirect      = 0;
        m_flush         = 0;
        m_misaligned    = 0;
    endtask

    task automatic setIdle();
        ex_valid = 1'b0;
        taken    = 1'b0;
        opcode   = 5'b00100;
        ex_pc    = 32'h0;
        imm      = 32'h0;
        rs1      = 32'h0;
    endtask

    task automatic setReq(input logic [4:0] op, input logic [31:0] pc_v,
                          input logic [31:0] imm_v, input logic [31:0] rs1_v);
        ex_valid = 1'b1;
        taken    = 1'b1;
        opcode   = op;
        ex_pc    = pc_v;
        imm      = imm_v;
        rs1      = rs1_v;
    endtask

    // Advance the model by one clock edge using the inputs that are present now.
    task automatic modelEdge();
        bit          jump_kind;
        bit          accepted;
        logic [31:0] tgt;
        jump_kind = ex_valid && taken &&
                    (opcode == 5'b11000 || opcode == 5'b11011 || opcode == 5'b11001);
        tgt = (opcode == 5'b11001) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (ex_pc + imm);
        accepted = jump_kind && (m_squash_left == 0) && !m_parked;
        m_redirect   = 0;
        m_misaligned = 0;
        if (accepted) begin
            m_squash_left = FLUSH_CYCLES;
            if (tgt[1]) begin
                m_misaligned = 1;
                if (!stall) m_pc = m_pc + 32'd4;
            end else if (stall) begin
                m_parked        = 1;
                m_parked_target = tgt;
            end else begin
                m_pc       = tgt;
                m_redirect = 1;
            end
        end else begin
            if (!stall && m_squash_left > 0) m_squash_left--;
            if (!stall && m_parked) begin
                m_pc       = m_parked_target;
                m_parked   = 0;
                m_redirect = 1;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
        m_flush = (m_squash_left != 0);
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".pc"},       pc,                 m_pc);
        checkOutput({tag, ".redirect"}, 32'(redirect),      32'(m_redirect));
        checkOutput({tag, ".flush"},    32'(flush),         32'(m_flush));
        checkOutput({tag, ".misalign"}, 32'(misaligned),    32'(m_misaligned));
        checkOutput({tag, ".link"},     link_addr,          ex_pc + 32'd4);
    endtask

    // One clock: model steps on the pre-edge inputs, outputs sampled 1 after.
    task automatic applyStimulus(input string tag);
        modelEdge();
        @(posedge clk);
        #1;
        compareAll(tag);
    endtask

    initial begin
        checks_done   = 0;
        checks_failed = 0;
        stall         = 1'b0;
        setIdle();
        modelReset();

        rst_n = 1'b0;
        #12;
        compareAll("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // The release edge itself may or may not be seen as out of reset.
        // Resync at a clean point so the model is not off by one.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        modelReset();

        $display("[TB] sequential fetch");
        applyStimulus("seq0");
        checkOutput("seq_pc4", pc, 32'h4);
        applyStimulus("seq1");
        applyStimulus("seq2");
        checkOutput("seq_pcC", pc, 32'hC);

        $display("[TB] BEQ taken");
        setReq(5'b11000, 32'h100, 32'h20, 32'h0);
        applyStimulus("beq");
        checkOutput("beq_target", pc, 32'h120);
        checkOutput("beq_redirect", 32'(redirect), 32'h1);
        setReq(5'b11011, 32'h300, 32'h40, 32'h0);
        applyStimulus("beq_shadow0");
        checkOutput("beq_ignored", pc, 32'h124);
        applyStimulus("beq_shadow1");
        checkOutput("beq_flush_done", 32'(flush), 32'h0);
        setIdle();

        $display("[TB] JALR misaligned");
        setReq(5'b11001, 32'h500, 32'h4, 32'h2003);
        applyStimulus("jalr_mis");
        checkOutput("jalr_mis_pc", pc, 32'h12C);
        checkOutput("jalr_mis_flag", 32'(misaligned), 32'h1);
        setIdle();
        applyStimulus("jalr_mis_a");
        applyStimulus("jalr_mis_b");

        $display("[TB] JAL under stall");
        setReq(5'b11011, 32'h40, 32'h80, 32'h0);
        stall = 1'b1;
        applyStimulus("jal_st0");
        setIdle();
        applyStimulus("jal_st1");
        applyStimulus("jal_st2");
        checkOutput("jal_hold", pc, 32'h134);
        checkOutput("jal_flush_stall", 32'(flush), 32'h1);
        stall = 1'b0;
        applyStimulus("jal_release");
        checkOutput("jal_target", pc, 32'hC0);
        applyStimulus("jal_after");

        $display("[TB] PC wrap");
        setReq(5'b11000, 32'hFFFF_FFF0, 32'hC, 32'h0);
        applyStimulus("wrap_jump");
        checkOutput("wrap_top", pc, 32'hFFFF_FFFC);
        setIdle();
        applyStimulus("wrap_step");
        checkOutput("wrap_zero", pc, 32'h0);
        applyStimulus("wrap_drain");
        setReq(5'b11000, 32'hFFFF_FFF0, 32'h20, 32'h0);
        applyStimulus("wrap_branch");
        checkOutput("wrap_target", pc, 32'h10);
        setIdle();
        applyStimulus("wrap_d0");
        applyStimulus("wrap_d1");

        $display("[TB] reset while parked");
        setReq(5'b11011, 32'h40, 32'h200, 32'h0);
        stall = 1'b1;
        applyStimulus("rst_park");
        setIdle();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("rst_async");
        stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus("rst_after");
        checkOutput("rst_no_stale", pc, RESET_PC + 32'd4);

        $display("[TB] random run");
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] pick;
            pick     = 3'($urandom_range(0, 7));
            stall    = ($urandom_range(0, 9) < 3);
            ex_valid = ($urandom_range(0, 3) != 0);
            taken    = ($urandom_range(0, 1) != 0);
            case (pick)
                3'd0, 3'd1, 3'd2: opcode = 5'b11000;
                3'd3, 3'd4:       opcode = 5'b11011;
                3'd5, 3'd6:       opcode = 5'b11001;
                default:          opcode = 5'b01100;
            endcase
            ex_pc = $urandom() & 32'hFFFF_FFFC;
            imm   = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFE)
                                                : ($urandom() & 32'hFFFF_FFFC);
            rs1   = $urandom();
            applyStimulus("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-side program counter register and control-flow redirect controller for the RV32I core. It consumes the branch/jump decision produced in EX (taken flag, opcode bits 6:2, EX PC, immediate, rs1) and computes the redirect target. It steers the fetch PC to that target and squashes the wrong-path instructions in IF/ID. It also holds a redirect that arrives during a fetch stall and flags misaligned control-flow targets.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FLUSH_CYCLES, 2, number of unstalled cycles flush_out stays high after an accepted redirect. Legal range is 1..7.

- clk_in  input  1  core clock; all state updates on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- stall_in  input  1  fetch stall; PC holds while it is high.
- ex_valid_in  input  1  the EX stage holds a valid instruction.
- branch_taken_in  input  1  taken flag from the EX branch comparator. It is 1 for JAL/JALR.
- opcode_6_to_2_in  input  5  EX opcode bits [6:2]: 11000 = branch, 11011 = JAL, 11001 = JALR.
- ex_pc_in  input  32  PC of the EX instruction.
- imm_in  input  32  sign-extended immediate of the EX instruction.
- rs1_in  input  32  forwarded rs1 value, used by JALR.
- pc_out  output  32  registered fetch PC.
- link_addr_out  output  32  combinational ex_pc_in + 4, the rd write value for JAL/JALR.
- redirect_out  output  1  registered one-cycle pulse: the PC was loaded with a redirect target on the previous edge.
- flush_out  output  1  registered IF/ID squash.
- misaligned_out  output  1  registered one-cycle pulse: an instruction-address-misaligned target was detected.

## Operation
- Request condition: req = ex_valid_in & branch_taken_in & opcode ∈ {11000, 11011, 11001} & (flush counter == 0) & !pending_valid.
- Target for branch and JAL: ex_pc_in + imm_in, modulo 2^32.
- Target for JALR: (rs1_in + imm_in) & ~32'h1, modulo 2^32.
- Misaligned condition: req & target[1].
  - Misaligned_out pulses for the next cycle and the flush counter loads.
  - PC is not redirected and continues its normal sequence. No pending state is created.
- Aligned request with stall_in = 0:
  - pc ← target and redirect_out pulses.
  - The flush counter loads FLUSH_CYCLES.
- Aligned request with stall_in = 1:
  - pending_valid ← 1 and pending_target ← target. The flush counter loads FLUSH_CYCLES.
  - On the first edge with stall_in = 0: pc ← pending_target, pending_valid ← 0, and redirect_out pulses.
- No request, no pending redirect, stall_in = 0: pc ← pc + 4, wrapping 32'hFFFF_FFFC → 32'h0000_0000.
- stall_in = 1 with no pending release: pc holds.
- Flush counter: 3-bit. It loads as described above and decrements on every edge where stall_in = 0 and it is nonzero.
- flush_out is registered as (next counter != 0).
- Requests are ignored while the counter is nonzero or a redirect is pending. These come from wrong-path instructions.

## Timing
- Reset (rst_n_in low, asynchronous):
  - pc_out = RESET_PC.
  - redirect_out = flush_out = misaligned_out = 0.
  - Counter = 0, pending_valid = 0, pending_target = 0.
  - Reset mid-flush or mid-pending discards all state immediately.
- Redirect latency: a request sampled at edge N gives pc_out = target after edge N when unstalled.
  - redirect_out and flush_out are high in the cycle after edge N.
  - flush_out stays high for FLUSH_CYCLES unstalled cycles.
- A stalled cycle neither advances the PC nor consumes flush cycles. flush_out remains high through the stall.
- A stall rising in the same cycle as the request has the stall take priority, and the request goes to pending.
- Only one redirect can be in flight at a time, so a simultaneous second request is impossible by construction.
- link_addr_out has zero latency and is purely combinational.

## Test plan
- Reset, then run 3 unstalled cycles → pc_out sequence 0, 4, 8, C. All flags stay 0.
- BEQ taken at ex_pc 0x100, imm 0x20 → next cycle pc_out = 0x120. redirect_out high 1 cycle, flush_out high 2 cycles. A taken request presented during those 2 cycles is ignored.
- JALR with rs1 0x2003, imm 0x4 → pc_out = 0x2006 is misaligned. misaligned_out pulses and flush_out asserts. PC continues +4 from its current value.
- JAL at ex_pc 0x40, imm 0x80, with stall_in high for 3 cycles → pc_out holds through the stall and flush_out stays high. On stall release pc_out = 0xC0, redirect_out pulses, and flush_out then falls after 2 cycles.
- pc at 0xFFFF_FFFC unstalled → next pc_out = 0x0000_0000. Branch with ex_pc 0xFFFF_FFF0, imm 0x20 → target 0x0000_0010.
- Assert rst_n_in mid-pending with flush_out high → outputs return to reset values asynchronously. After release, no stale redirect occurs and pc_out = RESET_PC.
